// File: rtl/carrier_gen.sv
// Programmable PWM carrier counter: up, down and up-down counting with prescaler,
// phase sync and shadowed period reload at the carrier endpoints.
module carrier_gen #(
  parameter int CW = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic [1:0]    count_mode,
  input  logic [PW-1:0] prescale,
  input  logic [CW-1:0] period_in,
  input  logic          sync_in,
  input  logic [CW-1:0] phase_in,
  output logic [CW-1:0] carrier,
  output logic [CW-1:0] period,
  output logic          dir,
  output logic          zero_evt,
  output logic          peak_evt
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_UPDN = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  mode_e         mode;
  logic [PW-1:0] pc;
  logic          tick;
  logic          upd;
  logic [CW-1:0] nxt_carrier;
  logic [CW-1:0] nxt_period;
  logic          nxt_dir;
  logic [CW-1:0] sync_carrier;

  assign mode = mode_e'(count_mode);

  // >= rather than == so a prescale lowered below the running count still ticks.
  assign tick = enable && (pc >= prescale);

  // Sync clamps to the active period so carrier never exceeds period.
  assign sync_carrier = (phase_in > period) ? period : phase_in;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nxt_carrier = carrier;
    nxt_period  = period;
    nxt_dir     = dir;
    upd         = 1'b0;
    if (tick) begin
      case (mode)
        MODE_UP: begin
          upd     = 1'b1;
          nxt_dir = 1'b1;
          if (carrier >= period) begin
            nxt_carrier = '0;
            nxt_period  = period_in;
          end else begin
            nxt_carrier = carrier + 1'b1;
          end
        end
        MODE_DOWN: begin
          upd     = 1'b1;
          nxt_dir = 1'b0;
          if (carrier == '0) begin
            nxt_carrier = period_in;
            nxt_period  = period_in;
          end else begin
            nxt_carrier = carrier - 1'b1;
          end
        end
        MODE_UPDN: begin
          upd = 1'b1;
          if (dir) begin
            if (carrier >= period) begin
              nxt_dir     = 1'b0;
              nxt_carrier = (period == '0) ? '0 : period - 1'b1;
            end else begin
              nxt_carrier = carrier + 1'b1;
            end
          end else if (carrier == '0) begin
            // Turn-around at zero is the reload point for up-down counting.
            nxt_dir     = 1'b1;
            nxt_period  = period_in;
            nxt_carrier = (period_in == '0) ? '0 : CW'(1);
          end else begin
            nxt_carrier = carrier - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc       <= '0;
      carrier  <= '0;
      period   <= '0;
      dir      <= 1'b1;
      zero_evt <= 1'b0;
      peak_evt <= 1'b0;
    end else if (!enable) begin
      pc       <= '0;
      zero_evt <= 1'b0;
      peak_evt <= 1'b0;
    end else if (sync_in) begin
      pc       <= '0;
      carrier  <= sync_carrier;
      dir      <= (mode != MODE_DOWN);
      zero_evt <= 1'b0;
      peak_evt <= 1'b0;
    end else begin
      pc       <= tick ? '0 : pc + 1'b1;
      carrier  <= nxt_carrier;
      period   <= nxt_period;
      dir      <= nxt_dir;
      // Events fire only on the edge a tick loads the endpoint value.
      zero_evt <= upd && (nxt_carrier == '0);
      peak_evt <= upd && (nxt_carrier == nxt_period);
    end
  end

endmodule

// File: tb/tb_carrier_gen.sv
// Directed bench for carrier_gen: stimulus pushes hand-computed expectations into a
// queue; a monitor pops one entry after each clock edge and compares all outputs.
module tb_carrier_gen;

  localparam int CW = 16;
  localparam int PW = 8;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [CW-1:0] p;
    logic          d;
    logic          z;
    logic          k;
  } obs_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic [1:0]    count_mode;
  logic [PW-1:0] prescale;
  logic [CW-1:0] period_in;
  logic          sync_in;
  logic [CW-1:0] phase_in;
  logic [CW-1:0] carrier;
  logic [CW-1:0] period;
  logic          dir;
  logic          zero_evt;
  logic          peak_evt;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  string tag_q[$];

  carrier_gen #(.CW(CW), .PW(PW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .count_mode (count_mode),
    .prescale   (prescale),
    .period_in  (period_in),
    .sync_in    (sync_in),
    .phase_in   (phase_in),
    .carrier    (carrier),
    .period     (period),
    .dir        (dir),
    .zero_evt   (zero_evt),
    .peak_evt   (peak_evt)
  );

  always #5 clk = ~clk;

  function automatic obs_t observed();
    obs_t o;
    o.c = carrier;
    o.p = period;
    o.d = dir;
    o.z = zero_evt;
    o.k = peak_evt;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got carrier=%0d period=%0d dir=%0b zero=%0b peak=%0b, expected carrier=%0d period=%0d dir=%0b zero=%0b peak=%0b",
               name, act.c, act.p, act.d, act.z, act.k, exp.c, exp.p, exp.d, exp.z, exp.k);
    end
  endtask

  // Queue the outputs expected after the coming posedge, then advance to the next negedge.
  task automatic cyc(input string name, input int c, input int p, input logic d,
                     input logic z, input logic k);
    obs_t e;
    e.c = c[CW-1:0];
    e.p = p[CW-1:0];
    e.d = d;
    e.z = z;
    e.k = k;
    exp_q.push_back(e);
    tag_q.push_back(name);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted away from any edge; outputs must clear at once.
  task automatic reset_pulse(input string name);
    obs_t r;
    r = '0;
    r.d = 1'b1;
    #2 resetn = 1'b0;
    #1 check(name, observed(), r);
    @(negedge clk);
    check({name, "_held"}, observed(), r);
    resetn = 1'b1;
  endtask

  // Monitor: compares one queued expectation after every clock edge.
  initial begin
    obs_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, observed(), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t rst_v;
    rst_v   = '0;
    rst_v.d = 1'b1;
    resetn = 1'b0; enable = 1'b0; count_mode = 2'b00; prescale = '0;
    period_in = '0; sync_in = 1'b0; phase_in = '0;
    #12 check("reset", observed(), rst_v);
    @(negedge clk);
    resetn = 1'b1;

    // Up counting, period 4, then period change 4->6 at carrier=2.
    enable = 1'b1; period_in = 16'd4;
    cyc("up_0", 0, 4, 1, 1, 0);
    cyc("up_1", 1, 4, 1, 0, 0);
    cyc("up_2", 2, 4, 1, 0, 0);
    cyc("up_3", 3, 4, 1, 0, 0);
    cyc("up_4", 4, 4, 1, 0, 1);
    cyc("up_wrap", 0, 4, 1, 1, 0);
    cyc("up_1b", 1, 4, 1, 0, 0);
    cyc("up_2b", 2, 4, 1, 0, 0);
    period_in = 16'd6;
    cyc("shadow_3", 3, 4, 1, 0, 0);
    cyc("shadow_4", 4, 4, 1, 0, 1);
    cyc("shadow_wrap", 0, 6, 1, 1, 0);
    for (int i = 1; i <= 5; i++) cyc("p6_run", i, 6, 1, 0, 0);
    cyc("p6_peak", 6, 6, 1, 0, 1);
    cyc("p6_wrap", 0, 6, 1, 1, 0);

    // Up-down from reset (period 0 first turn), then period 3.
    reset_pulse("rst_mid");
    count_mode = 2'b10; period_in = 16'd3;
    cyc("ud_p0", 0, 0, 0, 1, 1);
    cyc("ud_reload", 1, 3, 1, 0, 0);
    cyc("ud_2", 2, 3, 1, 0, 0);
    cyc("ud_peak", 3, 3, 1, 0, 1);
    cyc("ud_turn", 2, 3, 0, 0, 0);
    cyc("ud_1", 1, 3, 0, 0, 0);
    cyc("ud_zero", 0, 3, 0, 1, 0);
    cyc("ud_rise", 1, 3, 1, 0, 0);
    cyc("ud_2b", 2, 3, 1, 0, 0);

    // Prescale 2, up, period 2: each value held three clocks.
    reset_pulse("rst_ps");
    count_mode = 2'b00; period_in = 16'd2; prescale = 8'd2;
    cyc("ps_wait0", 0, 0, 1, 0, 0);
    cyc("ps_wait1", 0, 0, 1, 0, 0);
    cyc("ps_tick0", 0, 2, 1, 1, 0);
    cyc("ps_hold0", 0, 2, 1, 0, 0);
    cyc("ps_hold0", 0, 2, 1, 0, 0);
    cyc("ps_tick1", 1, 2, 1, 0, 0);
    cyc("ps_hold1", 1, 2, 1, 0, 0);
    cyc("ps_hold1", 1, 2, 1, 0, 0);
    cyc("ps_peak", 2, 2, 1, 0, 1);
    cyc("ps_hold2", 2, 2, 1, 0, 0);
    cyc("ps_hold2", 2, 2, 1, 0, 0);
    cyc("ps_wrap", 0, 2, 1, 1, 0);

    // Prescale 1 up to carrier 3 with period 6, then freeze via enable.
    period_in = 16'd6; prescale = 8'd1;
    cyc("p1_wait", 0, 2, 1, 0, 0);
    cyc("p1_1", 1, 2, 1, 0, 0);
    cyc("p1_wait", 1, 2, 1, 0, 0);
    cyc("p1_peak", 2, 2, 1, 0, 1);
    cyc("p1_wait", 2, 2, 1, 0, 0);
    cyc("p1_wrap", 0, 6, 1, 1, 0);
    cyc("p1_wait", 0, 6, 1, 0, 0);
    cyc("p1_1b", 1, 6, 1, 0, 0);
    cyc("p1_wait", 1, 6, 1, 0, 0);
    cyc("p1_2b", 2, 6, 1, 0, 0);
    cyc("p1_wait", 2, 6, 1, 0, 0);
    cyc("p1_3b", 3, 6, 1, 0, 0);
    cyc("pc_mid", 3, 6, 1, 0, 0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc("frozen", 3, 6, 1, 0, 0);
    enable = 1'b1;
    cyc("resume_wait", 3, 6, 1, 0, 0);
    cyc("resume_tick", 4, 6, 1, 0, 0);

    // Sync: ignored while disabled, clamps to period, suppresses events.
    enable = 1'b0; sync_in = 1'b1; phase_in = 16'd10;
    cyc("sync_disabled", 4, 6, 1, 0, 0);
    enable = 1'b1;
    cyc("sync_clamp6", 6, 6, 1, 0, 0);
    sync_in = 1'b0; prescale = 8'd0; period_in = 16'd5;
    cyc("post_sync_wrap", 0, 5, 1, 1, 0);
    sync_in = 1'b1;
    cyc("sync_clamp5", 5, 5, 1, 0, 0);
    sync_in = 1'b0;
    cyc("sync_then_wrap", 0, 5, 1, 1, 0);

    // Down mode via sync, reload to period at zero, hold mode, back to up.
    count_mode = 2'b01; sync_in = 1'b1; phase_in = 16'd2;
    cyc("sync_down", 2, 5, 0, 0, 0);
    sync_in = 1'b0; period_in = 16'd3;
    cyc("dn_1", 1, 5, 0, 0, 0);
    cyc("dn_zero", 0, 5, 0, 1, 0);
    cyc("dn_reload", 3, 3, 0, 0, 1);
    cyc("dn_2", 2, 3, 0, 0, 0);
    count_mode = 2'b11;
    cyc("hold_a", 2, 3, 0, 0, 0);
    cyc("hold_b", 2, 3, 0, 0, 0);
    count_mode = 2'b00;
    cyc("up_dir_force", 3, 3, 1, 0, 1);
    cyc("up_wrap3", 0, 3, 1, 1, 0);

    // Reset mid-count and restart.
    cyc("pre_rst", 1, 3, 1, 0, 0);
    reset_pulse("rst_end");
    cyc("restart", 0, 3, 1, 1, 0);

    begin
      obs_t drained;
      obs_t none;
      drained = '0;
      none    = '0;
      drained.c = CW'(exp_q.size());
      check("queue_drained", drained, none);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
